fetch_unit: RTL
===============

# fetch_unit

Instruction prefetch stage between `memory_controller` and the `processor` decode stage. It issues word-addressed instruction reads on the memory interface and captures the returned words with their fetch address and abort status in a DEPTH-entry FIFO. It presents them to decode through a valid/ready handshake. A redirect from execute, on a branch or a PC write, flushes all buffered and in-flight fetches and restarts fetching at the new address.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0: first fetch word address after reset.
- clk  input  1  clock; all state updates on the rising edge.
- n_reset  input  1  reset, asynchronous and active-low.
- addr  output  32  fetch word address; registered.
- trans  output  2  2'b00 idle, 2'b10 non-sequential, 2'b11 sequential; registered.
- write  output  1  tied 0.
- rdata  input  32  read data; valid in the cycle after the request cycle.
- abort  input  1  abort flag for the request that `rdata` belongs to; same timing as `rdata`.
- redirect  input  1  flush and restart; single-cycle pulse.
- redirect_pc  input  32  restart word address; sampled when `redirect` = 1.
- instr  output  32  instruction at the FIFO head.
- instr_pc  output  32  word address of `instr`.
- instr_abort  output  1  the head entry was fetched with `abort` = 1.
- instr_valid  output  1  the FIFO is non-empty.
- instr_ready  input  1  decode accepts the head entry.

## Operation
- A request is active in any cycle with `trans` ≠ 00.
  - The memory returns the word in the next cycle.
  - The unit writes it to the FIFO at the end of that next cycle, together with its `addr` and `abort`.
- One in-flight slot register records, for the response currently returning, its address and a `drop` flag.
- Credit rule: the unit presents a new request in the next cycle only if (FIFO count after this edge) + (number of responses still to be written) + 1 ≤ DEPTH. This guarantees the FIFO never overflows.
- Fetch state machine:
  - NONSEQ: presents `redirect_pc`/RESET_PC with `trans` = 10.
  - SEQ: presents previous `addr` + 1 with `trans` = 11.
  - STALL: `trans` = 00, `addr` holds its last value.
- Transitions:
  - After reset, go to NONSEQ.
  - From NONSEQ or SEQ, go to SEQ if there is credit, otherwise STALL.
  - From STALL, go to NONSEQ at `addr` + 1 when credit returns. Every restart after an idle cycle is non-sequential.
  - `redirect` forces NONSEQ at `redirect_pc` from any state.
- Abort: an aborted response is enqueued with `instr_abort` = 1. After that the unit issues no further requests (HALT state, `trans` = 00) until `redirect`. A response already in flight when the abort arrives is still enqueued.
- Redirect, sampled at edge R:
  - The FIFO is cleared.
  - Any response returning in cycle R+1 is marked `drop` and not enqueued.
  - A response captured at edge R itself is also discarded: flush wins over push.
- Dequeue: the head is popped when `instr_valid` and `instr_ready` are both 1 at an edge. Push and pop in the same edge are both performed. Redirect in the same edge discards the pop.
- `addr` increments modulo 2^32. 32'hFFFFFFFF → 0 stays SEQ.
- The `instr*` outputs come from the head register, with no combinational path from `rdata`. While `instr_valid` = 0 their values are don't-care, except after reset.

## Timing
- Reset values: `addr` = RESET_PC, `trans` = 00, `write` = 0, `instr_valid` = 0, `instr` = 0, `instr_pc` = 0, `instr_abort` = 0. FIFO empty, in-flight slot empty.
- Reset release to first request: edge 1 after release sets `trans` = 10, `addr` = RESET_PC.
- The memory samples at edge 2; the FIFO writes at edge 3; `instr_valid` = 1 from edge 3.
- Redirect at edge R: the new request is presented in cycle R+1, and `instr_valid` is 0 from R through R+2. The first new instruction is valid after edge R+3.
- Steady state with `instr_ready` held at 1: one instruction per cycle, with no bubbles.
- `n_reset` asserted mid-operation immediately clears all state and outputs to their reset values. In-flight responses are ignored, because the in-flight slot is cleared.

## Test plan
- Reset release, memory holds mem[i] = 32'hE000_0000 + i, `instr_ready` = 1 → `instr`/`instr_pc` = E0000000/0, E0000001/1, ... on consecutive cycles from edge 3; `trans` sequence 10, 11, 11, ...
- `instr_ready` = 0 for 10 cycles → `trans` = 00 after the FIFO holds DEPTH = 4 entries; no entry lost or duplicated. `ready` = 1 → entries 0..3 drain in order, then a NONSEQ restart at `addr` 4.
- Redirect to 32'h100 while the FIFO is full and a response is in flight → no entry with `instr_pc` < 32'h100 appears after the redirect edge. The first valid `instr_pc` = 32'h100, 3 edges later.
- `abort` = 1 on the response for `addr` 5 → entry 5 has `instr_abort` = 1, and entry 6, already in flight, is delivered. `trans` = 00 until a redirect to 32'h20, after which fetching resumes normally.
- Redirect in the same edge as a valid handshake and as a response push → neither the pop nor the push takes effect; the FIFO is empty afterwards.
- RESET_PC = 32'hFFFF_FFFE → `instr_pc` sequence FFFFFFFE, FFFFFFFF, 0, 1 with `trans` = 11 across the wrap. `n_reset` pulsed low mid-stream → outputs return to reset values immediately.

Source files
------------

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit_if
//  Purpose  : Bundles the memory request/response bus, the execute redirect
//             and the decode valid/ready handshake of the fetch unit.
//  Revision : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
    // Memory side
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [31:0] rdata;
    logic        abort;
    // Execute side
    logic        redirect;
    logic [31:0] redirect_pc;
    // Decode side
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_abort;
    logic        instr_valid;
    logic        instr_ready;

    // The fetch unit itself
    modport master (
        output addr, trans, write, instr, instr_pc, instr_abort, instr_valid,
        input  rdata, abort, redirect, redirect_pc, instr_ready
    );

    // Memory, execute and decode as seen from the surrounding pipeline
    modport slave (
        input  addr, trans, write, instr, instr_pc, instr_abort, instr_valid,
        output rdata, abort, redirect, redirect_pc, instr_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction prefetch stage. Issues word-addressed reads, keeps
//             the returned words with their address and abort flag in a
//             DEPTH-entry FIFO and hands them to decode via valid/ready.
//             A redirect flushes everything buffered or in flight.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic          clk,
    input  logic          n_reset,
    fetch_unit_if.master  bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] C_TRANS_IDLE   = 2'b00;
    localparam logic [1:0] C_TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] C_TRANS_SEQ    = 2'b11;

    // START is the idle cycle that precedes every launch after reset or
    // redirect; it gives the redirect its one-cycle turnaround.
    typedef enum logic [2:0] {
        ST_START  = 3'd0,
        ST_NONSEQ = 3'd1,
        ST_SEQ    = 3'd2,
        ST_STALL  = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // Fetch state and registered bus outputs
    state_t      state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic [1:0]  trans_q, trans_d;

    // In-flight slot: describes the response returning in the current cycle
    logic        slot_valid_q, slot_valid_d;
    logic [31:0] slot_addr_q,  slot_addr_d;
    logic        slot_drop_q,  slot_drop_d;

    // FIFO storage and pointers
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      pc_d   [DEPTH];
    logic             abt_q  [DEPTH];
    logic             abt_d  [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic push;
    logic pop;
    logic abort_seen;
    logic outstanding;
    logic credit;

    // A flush in the same edge beats both the push and the pop.
    assign push       = slot_valid_q && !slot_drop_q && !bus.redirect;
    assign pop        = (count_q != '0) && bus.instr_ready && !bus.redirect;
    assign abort_seen = push && bus.abort;

    // Capture the request being presented now so its response can be tagged
    always_comb begin
        slot_valid_d = (trans_q != C_TRANS_IDLE);
        slot_addr_d  = addr_q;
        slot_drop_d  = bus.redirect;
    end

    // FIFO next-state: flush, push of the returning word, pop by decode
    always_comb begin
        data_d   = data_q;
        pc_d     = pc_q;
        abt_d    = abt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                data_d[wr_ptr_q] = bus.rdata;
                pc_d[wr_ptr_q]   = slot_addr_q;
                abt_d[wr_ptr_q]  = bus.abort;
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Credit: room for everything still owed plus one more request
    always_comb begin
        outstanding = slot_valid_d && !slot_drop_d;
        credit      = (32'(count_d) + 32'(outstanding) + 32'd1) <= 32'(DEPTH);
    end

    // Fetch state machine: next address, transfer type and state
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        trans_d = C_TRANS_IDLE;
        if (bus.redirect) begin
            state_d = ST_START;
            addr_d  = bus.redirect_pc;
        end else if (abort_seen || (state_q == ST_HALT)) begin
            state_d = ST_HALT;
        end else begin
            case (state_q)
                ST_START: begin
                    state_d = ST_NONSEQ;
                    trans_d = C_TRANS_NONSEQ;
                end
                ST_NONSEQ, ST_SEQ: begin
                    if (credit) begin
                        state_d = ST_SEQ;
                        addr_d  = addr_q + 32'd1;
                        trans_d = C_TRANS_SEQ;
                    end else begin
                        state_d = ST_STALL;
                    end
                end
                ST_STALL: begin
                    // Any restart after an idle cycle is non-sequential
                    if (credit) begin
                        state_d = ST_NONSEQ;
                        addr_d  = addr_q + 32'd1;
                        trans_d = C_TRANS_NONSEQ;
                    end
                end
                default: begin
                    state_d = ST_START;
                end
            endcase
        end
    end

    // Fetch state, bus outputs and in-flight slot registers
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= ST_START;
            addr_q       <= RESET_PC;
            trans_q      <= C_TRANS_IDLE;
            slot_valid_q <= 1'b0;
            slot_addr_q  <= '0;
            slot_drop_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            trans_q      <= trans_d;
            slot_valid_q <= slot_valid_d;
            slot_addr_q  <= slot_addr_d;
            slot_drop_q  <= slot_drop_d;
        end
    end

    // FIFO storage and pointer registers
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            data_q   <= '{default: '0};
            pc_q     <= '{default: '0};
            abt_q    <= '{default: 1'b0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            data_q   <= data_d;
            pc_q     <= pc_d;
            abt_q    <= abt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign bus.addr        = addr_q;
    assign bus.trans       = trans_q;
    assign bus.write       = 1'b0;
    assign bus.instr       = data_q[rd_ptr_q];
    assign bus.instr_pc    = pc_q[rd_ptr_q];
    assign bus.instr_abort = abt_q[rd_ptr_q];
    assign bus.instr_valid = (count_q != '0);

endmodule
`default_nettype wire
